// File: rtl/i_mem_loader_if.sv
// rtl/i_mem_loader_if.sv - byte stream in / instruction-memory write port out, grouped for i_mem_loader.
interface i_mem_loader_if #(
  parameter int tamanho       = 32,
  parameter int enderecamento = 10
);
  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     wr_en;
  logic [enderecamento-1:0] wr_addr;
  logic [tamanho-1:0]       wr_data;

  // master is the loader: it consumes the stream and drives the memory write port
  modport master (
    input  byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/i_mem_loader.sv
// rtl/i_mem_loader.sv - boot-time instruction loader: byte stream to big-endian words written into I-memory.
// Optional trailing XOR checksum byte enabled by defining I_MEM_LOADER_CHECKSUM_EN.
module i_mem_loader #(
  parameter int tamanho       = 32,
  parameter int enderecamento = 10,
  parameter int profundidade  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  i_mem_loader_if.master  bus
);
  localparam int IW = enderecamento + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              len_q;
  logic [IW-1:0]            widx_q;
  logic [1:0]               bidx_q;
  logic [enderecamento-1:0] wr_addr_q;
  logic [tamanho-1:0]       wr_data_q;
  logic                     byte_ready;
  logic                     xfer;
  logic                     idle_like;
  logic                     last_word;
  logic [15:0]              n_lo;
`ifdef I_MEM_LOADER_CHECKSUM_EN
  logic [7:0]               csum_q;
`endif

  assign xfer      = bus.byte_valid && byte_ready;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  // word count as it will be once LEN_LO is accepted this cycle
  assign n_lo      = {len_q[15:8], bus.byte_in};
  assign last_word = (32'(widx_q) + 32'd1) == 32'(len_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (n_lo == 16'd0)
`ifdef I_MEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          else if (int'(n_lo) > profundidade) state_d = S_ERR;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (xfer && bidx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word)
`ifdef I_MEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        else
          state_d = S_DATA;
      end
`ifdef I_MEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (xfer) state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef I_MEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      if (idle_like && start) begin
        widx_q <= '0;
        bidx_q <= '0;
`ifdef I_MEM_LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
      end
      if (state_q == S_LEN_HI && xfer) len_q[15:8] <= bus.byte_in;
      if (state_q == S_LEN_LO && xfer) len_q[7:0]  <= bus.byte_in;
      if (state_q == S_DATA && xfer) begin
        wr_data_q <= {wr_data_q[tamanho-9:0], bus.byte_in};
        bidx_q    <= bidx_q + 2'd1;
`ifdef I_MEM_LOADER_CHECKSUM_EN
        csum_q    <= csum_q ^ bus.byte_in;
`endif
        // address is latched with the final byte so it is stable throughout WRITE
        if (bidx_q == 2'd3) wr_addr_q <= widx_q[enderecamento-1:0];
      end
      if (state_q == S_WRITE) widx_q <= widx_q + 1'b1;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = (state_q == S_WRITE);
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cpu_hold       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);
endmodule
